// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Brief    : Instruction fetch unit with a circular prefetch queue. Issues one
//            outstanding word request at a time, queues returned words with
//            their addresses, and flushes/restarts on redirect. A request
//            made stale by a redirect is finished and its data dropped.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_ack,
   input  logic [31:0]              imem_rdata,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [31:0]              inst,
   output logic [31:0]              inst_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int                 c_PTR_W   = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W+1)'(DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [31:0]          r_fetch_pc;
   logic [31:0]          w_fetch_pc_nxt;
   logic [31:0]          r_req_addr;
   logic [c_PTR_W:0]     r_count;
   logic [c_PTR_W:0]     w_count_nxt;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [31:0]          r_mem_data [DEPTH];
   logic [31:0]          r_mem_pc   [DEPTH];
   logic                 w_push;
   logic                 w_pop;
   logic                 w_valid;
   logic [31:0]          w_redirect_target;

   // Redirect overrides both queue operations in the same cycle.
   assign w_push            = (r_state == S_REQ) && imem_ack && !redirect;
   assign w_valid           = (r_count != '0);
   assign w_pop             = w_valid && inst_ready && !redirect;
   assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

   // Next occupancy and next fetch address.
   always_comb begin
      w_count_nxt    = r_count;
      w_fetch_pc_nxt = r_fetch_pc;
      if (redirect) begin
         w_count_nxt    = '0;
         w_fetch_pc_nxt = w_redirect_target;
      end else begin
         w_count_nxt = r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_pop};
         if (w_push) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state and request output.
   always_comb begin
      w_state_nxt = r_state;
      imem_req    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!redirect && (r_count < c_FULL)) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            imem_req = 1'b1;
            if (redirect) begin
               w_state_nxt = imem_ack ? S_IDLE : S_DISCARD;
            end else if (imem_ack) begin
               w_state_nxt = (w_count_nxt < c_FULL) ? S_REQ : S_IDLE;
            end
         end
         S_DISCARD: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Fetch PC, request address latch, occupancy and queue pointers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         r_fetch_pc <= w_fetch_pc_nxt;
         r_count    <= w_count_nxt;
         // The address only moves when a new request starts, so a stale
         // request keeps its address while a redirect retargets fetch_pc.
         if (w_state_nxt == S_REQ) begin
            r_req_addr <= w_fetch_pc_nxt;
         end
         if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
      end
   end

   // Queue storage write; contents are only observed through valid entries.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= imem_rdata;
         r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
      end
   end

   assign imem_addr  = r_req_addr;
   assign count      = r_count;
   assign inst_valid = w_valid;
   // Empty queue presents zeros rather than stale or uninitialised storage.
   assign inst       = w_valid ? r_mem_data[r_rd_ptr] : 32'h0;
   assign inst_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_queue
// Brief    : Self-checking bench for inst_fetch_queue (DEPTH=4, RESET_PC=0).
//            Table rows hold the inputs applied in a cycle and the outputs
//            expected during that same cycle; corner cases follow by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [2:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .count      (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        redir;
      logic [31:0] rpc;
      logic        ack;
      logic [31:0] rdata;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [2:0]  e_cnt;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rd, input logic [31:0] rp, input logic ak,
                               input logic [31:0] dat, input logic ry, input logic e_req,
                               input logic [31:0] e_addr, input logic e_valid,
                               input logic [2:0] e_cnt, input logic [31:0] e_pc,
                               input logic [31:0] e_inst);
      vec_t v;
      v.redir = rd;  v.rpc = rp;  v.ack = ak;  v.rdata = dat;  v.rdy = ry;
      v.e_req = e_req;  v.e_addr = e_addr;  v.e_valid = e_valid;
      v.e_cnt = e_cnt;  v.e_pc = e_pc;  v.e_inst = e_inst;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Apply inputs for one cycle, then return at the following falling edge.
   task automatic step(input logic rd, input logic [31:0] rp, input logic ak,
                       input logic [31:0] dat, input logic ry);
      redirect    = rd;
      redirect_pc = rp;
      imem_ack    = ak;
      imem_rdata  = dat;
      inst_ready  = ry;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;  redirect = 1'b0;  redirect_pc = '0;
      imem_ack = 1'b0;  imem_rdata = '0;  inst_ready = 1'b0;

      //   redir rpc ack rdata          rdy | req addr          vld cnt pc            inst
      add(0, 0, 0, 32'h0,         1,  0, 32'h00, 0, 0, 32'h00, 32'h0);
      add(0, 0, 1, 32'h1000,      1,  1, 32'h00, 0, 0, 32'h00, 32'h0);
      add(0, 0, 1, 32'h1004,      1,  1, 32'h04, 1, 1, 32'h00, 32'h1000);
      add(0, 0, 1, 32'h1008,      1,  1, 32'h08, 1, 1, 32'h04, 32'h1004);
      add(0, 0, 1, 32'h100C,      0,  1, 32'h0C, 1, 1, 32'h08, 32'h1008);
      add(0, 0, 1, 32'h1010,      0,  1, 32'h10, 1, 2, 32'h08, 32'h1008);
      add(0, 0, 1, 32'h1014,      0,  1, 32'h14, 1, 3, 32'h08, 32'h1008);
      add(0, 0, 0, 32'h0,         0,  0, 32'h14, 1, 4, 32'h08, 32'h1008);
      add(0, 0, 0, 32'h0,         1,  0, 32'h14, 1, 4, 32'h08, 32'h1008);
      add(0, 0, 0, 32'h0,         0,  0, 32'h14, 1, 3, 32'h0C, 32'h100C);
      add(0, 0, 1, 32'h1018,      0,  1, 32'h18, 1, 3, 32'h0C, 32'h100C);
      add(0, 0, 0, 32'h0,         1,  0, 32'h18, 1, 4, 32'h0C, 32'h100C);
      add(0, 0, 0, 32'h0,         1,  0, 32'h18, 1, 3, 32'h10, 32'h1010);
      add(0, 0, 0, 32'h0,         1,  1, 32'h1C, 1, 2, 32'h14, 32'h1014);
      add(0, 0, 1, 32'h101C,      1,  1, 32'h1C, 1, 1, 32'h18, 32'h1018);
      add(0, 0, 0, 32'h0,         1,  1, 32'h20, 1, 1, 32'h1C, 32'h101C);
      add(0, 0, 0, 32'h0,         0,  1, 32'h20, 0, 0, 32'h00, 32'h0);

      // Reset state
      @(negedge clk);
      chk("rst req",   {31'd0, imem_req},   32'd0);
      chk("rst addr",  imem_addr,           32'h0);
      chk("rst valid", {31'd0, inst_valid}, 32'd0);
      chk("rst count", {29'd0, count},      32'd0);
      chk("rst inst",  inst,                32'h0);
      chk("rst pc",    inst_pc,             32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Streaming, back-pressure to full, and resume
      for (int i = 0; i < vecs.size(); i++) begin
         chk($sformatf("row%0d req", i),   {31'd0, imem_req},   {31'd0, vecs[i].e_req});
         chk($sformatf("row%0d addr", i),  imem_addr,           vecs[i].e_addr);
         chk($sformatf("row%0d valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
         chk($sformatf("row%0d count", i), {29'd0, count},      {29'd0, vecs[i].e_cnt});
         chk($sformatf("row%0d pc", i),    inst_pc,             vecs[i].e_pc);
         chk($sformatf("row%0d inst", i),  inst,                vecs[i].e_inst);
         step(vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rdata, vecs[i].rdy);
      end

      // Redirect while a request is outstanding: stale request keeps its address
      step(1, 32'h8, 0, 32'h0, 0);
      chk("disc req",  {31'd0, imem_req}, 32'd1);
      chk("disc addr", imem_addr,         32'h20);
      step(0, 32'h0, 1, 32'hBAD0_0000, 0);
      chk("disc done req",   {31'd0, imem_req}, 32'd0);
      chk("disc done count", {29'd0, count},    32'd0);
      step(0, 32'h0, 0, 32'h0, 0);
      chk("req8 addr", imem_addr, 32'h8);
      // Request at 8, redirect to 0x103, ack three cycles late
      step(1, 32'h0000_0103, 0, 32'h0, 0);
      chk("r33 req",  {31'd0, imem_req}, 32'd1);
      chk("r33 addr", imem_addr,         32'h8);
      step(0, 32'h0, 0, 32'h0, 0);
      step(0, 32'h0, 0, 32'h0, 0);
      chk("r33 hold addr", imem_addr, 32'h8);
      step(0, 32'h0, 1, 32'hBAD0_0008, 1);
      chk("r33 drop req",   {31'd0, imem_req},   32'd0);
      chk("r33 drop count", {29'd0, count},      32'd0);
      chk("r33 drop valid", {31'd0, inst_valid}, 32'd0);
      step(0, 32'h0, 0, 32'h0, 0);
      chk("r33 next req",  {31'd0, imem_req}, 32'd1);
      chk("r33 next addr", imem_addr,         32'h100);

      // Redirect coincident with ack while two entries are queued
      step(0, 32'h0, 1, 32'h2100, 0);
      step(0, 32'h0, 1, 32'h2104, 0);
      chk("r34 pre count", {29'd0, count}, 32'd2);
      chk("r34 pre pc",    inst_pc,        32'h100);
      chk("r34 pre inst",  inst,           32'h2100);
      step(1, 32'h200, 1, 32'hBAD0_0108, 0);
      chk("r34 count", {29'd0, count},      32'd0);
      chk("r34 valid", {31'd0, inst_valid}, 32'd0);
      chk("r34 req",   {31'd0, imem_req},   32'd0);
      step(0, 32'h0, 0, 32'h0, 0);
      chk("r34 next addr", imem_addr, 32'h200);
      step(0, 32'h0, 1, 32'h3000, 0);
      chk("r34 head inst",  inst,           32'h3000);
      chk("r34 head pc",    inst_pc,        32'h200);
      chk("r34 head count", {29'd0, count}, 32'd1);

      // Address wrap at the top of the address space
      step(1, 32'hFFFF_FFFC, 0, 32'h0, 0);
      step(0, 32'h0, 1, 32'hBAD0_0204, 0);
      step(0, 32'h0, 0, 32'h0, 0);
      chk("r35 addr", imem_addr, 32'hFFFF_FFFC);
      step(0, 32'h0, 1, 32'h4000, 0);
      chk("r35 pc0",   inst_pc,   32'hFFFF_FFFC);
      chk("r35 inst0", inst,      32'h4000);
      chk("r35 addr1", imem_addr, 32'h0);
      step(0, 32'h0, 1, 32'h4004, 1);
      chk("r35 pc1",   inst_pc,        32'h0);
      chk("r35 inst1", inst,           32'h4004);
      chk("r35 count", {29'd0, count}, 32'd1);

      // Asynchronous reset during a live request with three entries queued
      step(0, 32'h0, 1, 32'h5008, 0);
      step(0, 32'h0, 1, 32'h500C, 0);
      chk("r36 pre count", {29'd0, count},    32'd3);
      chk("r36 pre req",   {31'd0, imem_req}, 32'd1);
      redirect = 1'b0;  imem_ack = 1'b0;  inst_ready = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("r36 req",   {31'd0, imem_req},   32'd0);
      chk("r36 count", {29'd0, count},      32'd0);
      chk("r36 valid", {31'd0, inst_valid}, 32'd0);
      chk("r36 addr",  imem_addr,           32'h0);
      chk("r36 inst",  inst,                32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      chk("r36 rel req", {31'd0, imem_req}, 32'd0);
      step(0, 32'h0, 0, 32'h0, 0);
      chk("r36 first req",  {31'd0, imem_req}, 32'd1);
      chk("r36 first addr", imem_addr,         32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
